// File: rtl/bus_arbiter3_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter3_if
// Description : Bundle of the arbitration handshake between three requesters,
//               the shared resource and the bus_arbiter3 block.
//                 req [2:0] : request per requester (bit i = requester i)
//                 ack       : one-beat-complete pulse from the shared resource
//                 gnt [2:0] : one-hot registered grant, 000 when idle
//                 sel [1:0] : datapath mux select (binary index of gnt)
//                 en        : resource enable, high while gnt is non-zero
//                 err       : sticky "ack while idle" flag
//               master : arbiter side (drives gnt/sel/en/err)
//               slave  : requester/resource side (drives req/ack)
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter3_if;
    logic [2:0] req;
    logic       ack;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       en;
    logic       err;

    modport master (
        input  req,
        input  ack,
        output gnt,
        output sel,
        output en,
        output err
    );

    modport slave (
        output req,
        output ack,
        input  gnt,
        input  sel,
        input  en,
        input  err
    );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter3.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter3
// Description : Round-robin arbiter/sequencer for a three-way shared 16-bit
//               datapath port. Grants one requester at a time, drives the
//               3:1 mux select and limits each grant to MAXBEATS acknowledged
//               beats while another requester is waiting.
// Ports       : clk    - system clock, rising edge
//               reset  - asynchronous active-high reset
//               bus    - bus_arbiter3_if.master (req, ack in; gnt, sel, en,
//                        err out)
// Parameters  : MAXBEATS - beats per grant while others wait (1..15)
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter3 #(
    parameter int unsigned MAXBEATS = 4
) (
    input  wire            clk,
    input  wire            reset,
    bus_arbiter3_if.master bus
);

    // ------------------------------------------------------------------------
    // Constants and types
    // ------------------------------------------------------------------------
    localparam logic [4:0] c_maxbeats = 5'(MAXBEATS);
    localparam logic [1:0] c_last_rst = 2'd2;   // requester 0 wins first

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Helper functions (indices are always 0..2)
    // ------------------------------------------------------------------------
    function automatic logic [1:0] inc3(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            default: oh = 3'b100;
        endcase
        return oh;
    endfunction

    // First set bit of mask in the order last+1, last+2, last (mod 3).
    // Callers guarantee mask is non-zero.
    function automatic logic [1:0] pick(input logic [2:0] mask,
                                        input logic [1:0] last);
        logic [1:0] c1;
        logic [1:0] c2;
        logic [1:0] win;
        c1 = inc3(last);
        c2 = inc3(c1);
        if (mask[c1])
            win = c1;
        else if (mask[c2])
            win = c2;
        else
            win = last;
        return win;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t     r_state;
    logic [1:0] r_owner;
    logic [3:0] r_cnt;
    logic [1:0] r_last;
    logic [2:0] r_gnt;
    logic [1:0] r_sel;
    logic       r_en;
    logic       r_err;

    state_t     w_state_n;
    logic [1:0] w_owner_n;
    logic [3:0] w_cnt_n;
    logic [1:0] w_last_n;
    logic [2:0] w_gnt_n;
    logic [1:0] w_sel_n;
    logic       w_en_n;
    logic       w_err_n;

    logic       w_own_req;
    logic [2:0] w_others;
    logic [4:0] w_cnt_inc;
    logic       w_budget_hit;
    logic       w_release;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_owner <= 2'd0;
            r_cnt   <= 4'd0;
            r_last  <= c_last_rst;
            r_gnt   <= 3'b000;
            r_sel   <= 2'd0;
            r_en    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_owner <= w_owner_n;
            r_cnt   <= w_cnt_n;
            r_last  <= w_last_n;
            r_gnt   <= w_gnt_n;
            r_sel   <= w_sel_n;
            r_en    <= w_en_n;
            r_err   <= w_err_n;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_n = r_state;
        w_owner_n = r_owner;
        w_cnt_n   = r_cnt;
        w_last_n  = r_last;
        w_release = 1'b0;

        w_own_req    = bus.req[r_owner];
        // A non-owner request that rises together with the owner's ack
        // already counts as pending on this edge.
        w_others     = bus.req & ~onehot3(r_owner);
        w_cnt_inc    = {1'b0, r_cnt} + 5'd1;
        w_budget_hit = (w_cnt_inc == c_maxbeats);

        // ack in IDLE has no owner to account to; only flag it.
        w_err_n = r_err | ((r_state == ST_IDLE) && bus.ack);

        case (r_state)
            ST_IDLE: begin
                if (|bus.req) begin
                    w_state_n = ST_OWN;
                    w_owner_n = pick(bus.req, r_last);
                    w_last_n  = w_owner_n;
                    w_cnt_n   = 4'd0;
                end
            end

            ST_OWN: begin
                if (!w_own_req) begin
                    // Abandon (no ack) or final beat (ack) both release.
                    w_release = 1'b1;
                end else if (bus.ack) begin
                    if (w_budget_hit) begin
                        if (|w_others)
                            w_release = 1'b1;
                        else
                            w_cnt_n = 4'd0;   // nobody waiting: new budget
                    end else begin
                        w_cnt_n = w_cnt_inc[3:0];
                    end
                end

                if (w_release) begin
                    w_cnt_n = 4'd0;
                    if (|w_others) begin
                        // r_last equals the owner here, so the search starts
                        // just past it and the owner is masked out anyway.
                        w_owner_n = pick(w_others, r_last);
                        w_last_n  = w_owner_n;
                    end else begin
                        w_state_n = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_n = ST_IDLE;
            end
        endcase

        // Outputs are computed from the next state and registered, so there
        // is no combinational path from req/ack to gnt/sel/en.
        w_en_n  = (w_state_n == ST_OWN);
        w_gnt_n = w_en_n ? onehot3(w_owner_n) : 3'b000;
        w_sel_n = w_en_n ? w_owner_n : 2'd0;
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.gnt = r_gnt;
    assign bus.sel = r_sel;
    assign bus.en  = r_en;
    assign bus.err = r_err;

endmodule
`default_nettype wire

// File: doc/bus_arbiter3.md
# bus_arbiter3

Round-robin arbiter and sequencer for a three-way shared 16-bit datapath port. Three requesters compete for one downstream resource (memory or register-file write port). The block grants exactly one requester at a time and drives the 2-bit select of the 3:1 datapath multiplexer. It enforces a per-grant beat budget so that no requester can starve the other two.

## Interface
- MAXBEATS, default 4: maximum acknowledged beats per grant while another requester waits; legal range 1..15.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  3  request per requester; bit i = requester i; held high until served or abandoned.
- ack  input  1  one-cycle pulse from the shared resource; one beat completed for the current owner.
- gnt  output  3  one-hot registered grant; 000 when idle.
- sel  output  2  mux select: 00 = requester 0, 01 = requester 1, 10 = requester 2; 11 is never driven.
- en  output  1  resource enable; high exactly while gnt is non-zero.
- err  output  1  sticky flag; set by ack received while idle; cleared only by reset.

## Operation
- States: IDLE, OWN. The owner index (0..2) and the beat counter cnt (4 bits) are registered.
- Round-robin pointer last (0..2):
  - Search order is last+1, last+2, last (mod 3).
  - last updates to the new owner on every grant.
  - Reset value of last is 2, so requester 0 wins the first arbitration.
- IDLE:
  - If req != 000: grant the first requester in search order, go to OWN, clear cnt.
  - Otherwise stay in IDLE.
- OWN, evaluated every cycle with priority top to bottom:
  - req[owner]=0 and ack=0 (abandon): release.
  - ack=1 and req[owner]=0 (final beat): release.
  - ack=1, req[owner]=1, cnt+1 = MAXBEATS, and another req bit set: release; the budget is exhausted.
  - ack=1, req[owner]=1, cnt+1 = MAXBEATS, and no other req bit set: keep the grant, clear cnt.
  - ack=1 otherwise: cnt <= cnt+1.
  - No ack and req[owner]=1: hold.
- Release:
  - If any requester other than the owner has req=1, re-arbitrate among the others in search order and grant on the same edge (back-to-back, no idle cycle).
  - Otherwise go to IDLE.
  - The releasing owner is never re-granted on its own release edge.
- sel always equals the binary index of the set gnt bit. sel is 00 in IDLE.
- err is set on any edge where the state is IDLE and ack=1. The ack is otherwise ignored.

## Timing
- Reset values: gnt=000, sel=00, en=0, err=0; state IDLE, cnt=0, last=2. Reset takes effect immediately (asynchronous) and may occur mid-grant. The in-flight beat is dropped and no ack is accounted.
- Grant latency: req sampled high at edge n (from IDLE), so gnt, sel and en are valid after edge n.
- Release latency: the ack or req drop is sampled at edge n. The old grant is removed and the next grant applied at that same edge, so there are zero dead cycles between owners.
- gnt, sel and en are pure register outputs with no combinational path from req or ack.
- A simultaneous req rise from a non-owner and ack to the owner is treated as "another req pending" in the same cycle.
- cnt never exceeds MAXBEATS-1 and does not wrap.

## Test plan
- Reset/first grant: reset high, then low; req=111 at edge 1 → after edge 1, gnt=001, sel=00, en=1; after reset assertion mid-grant, all outputs return to reset values immediately.
- Rotation: req=111 held, ack every cycle, MAXBEATS=1 → gnt sequence 001, 010, 100, 001; sel 00, 01, 10, 00; no idle cycles.
- Budget: MAXBEATS=4, req=011 held, ack every cycle with requester 0 owning → requester 0 keeps gnt for 4 acks, then gnt=010 on the 4th ack edge. With req=001 only, requester 0 keeps gnt indefinitely and cnt clears every 4 beats.
- Abandon: requester 1 owns, req drops to 000 with no ack → gnt=000, en=0 after the next edge; a following req=010 is re-granted (the pointer skips nothing).
- Final beat with pending: owner 2, ack with req=001 (owner dropped) → gnt=001 on that edge, last=0.
- Error flag: state IDLE, ack pulse → err=1 after the edge, stays 1 through later grants until reset.
